// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   alu_sel_t : the eight operation codes carried on alu_sel
//   state_t   : control FSM states (IDLE, MUL, DIV, DONE)
// -----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_MUL = 3'b010,
      ALU_DIV = 3'b011,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           pulse: capture i_dividend / i_divisor and begin
//   i_dividend        numerator
//   i_divisor         denominator (caller guarantees non-zero)
//   o_done            high during the final iteration cycle
//   o_quotient        quotient, valid while o_done is high
// After a start, iterations run on the next WIDTH rising edges; o_done and
// o_quotient are combinational on the last one so the caller can register the
// answer on that same edge.
// -----------------------------------------------------------------------------
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient
);

   localparam int CW = $clog2(WIDTH);

   logic             r_busy;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_q;      // dividend shifts out the top, quotient in the bottom
   logic [WIDTH-1:0] r_b;

   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_q_next;

   always_comb begin
      w_rem_sh = {r_rem, r_q[WIDTH-1]};
      w_diff   = w_rem_sh - {1'b0, r_b};
      // Borrow out of the trial subtraction means restore the shifted value.
      if (w_diff[WIDTH]) begin
         w_rem_next = w_rem_sh[WIDTH-1:0];
         w_q_next   = {r_q[WIDTH-2:0], 1'b0};
      end else begin
         w_rem_next = w_diff[WIDTH-1:0];
         w_q_next   = {r_q[WIDTH-2:0], 1'b1};
      end
   end

   assign o_done     = r_busy && (r_cnt == CW'(WIDTH-1));
   assign o_quotient = w_q_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_q    <= '0;
         r_b    <= '0;
      end else if (i_start) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_q    <= i_dividend;
         r_b    <= i_divisor;
      end else if (r_busy) begin
         r_rem <= w_rem_next;
         r_q   <= w_q_next;
         if (r_cnt == CW'(WIDTH-1)) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Sequential ALU: single-cycle add/sub/and/or/sll/srl, WIDTH-cycle shift-add
// multiply, WIDTH-cycle restoring divide.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   alu_sel, op_a, op_b   operation and operands, captured on acceptance
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result, flag_z/n/c/v  registered result and flags, stable in DONE
//   div_by_zero           divide issued with op_b == 0
//   busy                  any state other than IDLE
//   dbg_state             current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload until then, and the consumer may drop ready at
// any time without affecting the payload.
// -----------------------------------------------------------------------------
import alu_pkg::*;

module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             div_by_zero,
   output logic             busy,
   output state_t           dbg_state
);

   localparam int CW = $clog2(WIDTH);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_result;
   logic             r_z, r_n, r_c, r_v, r_dbz;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_v, w_dbz;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_div_start;
   logic             w_div_done;
   logic [WIDTH-1:0] w_div_q;

   // Single-cycle results, computed straight from the request inputs so they
   // can be registered on the accepting edge.
   always_comb begin
      w_sum  = {1'b0, op_a} + {1'b0, op_b};
      w_diff = op_a - op_b;
      w_res  = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_dbz  = 1'b0;
      case (alu_sel_t'(alu_sel))
         ALU_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_SUB: begin
            w_res = w_diff;
            w_c   = (op_a >= op_b);
            w_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         ALU_AND: w_res = op_a & op_b;
         ALU_OR:  w_res = op_a | op_b;
         ALU_SLL: w_res = op_a << op_b[CW-1:0];
         ALU_SRL: w_res = op_a >> op_b[CW-1:0];
         ALU_DIV: begin
            // Only reaches the result register when the divisor is zero.
            w_res = '1;
            w_dbz = 1'b1;
         end
         default: w_res = '0;
      endcase
   end

   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_div_start = (r_state == ST_IDLE) && in_valid &&
                        (alu_sel_t'(alu_sel) == ALU_DIV) && (op_b != '0);

   iter_divider #(.WIDTH(WIDTH)) u_div (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (w_div_start),
      .i_dividend (op_a),
      .i_divisor  (op_b),
      .o_done     (w_div_done),
      .o_quotient (w_div_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_result <= '0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (alu_sel_t'(alu_sel) == ALU_MUL) begin
                     r_acc    <= '0;
                     r_mcand  <= op_a;
                     r_mplier <= op_b;
                     r_cnt    <= '0;
                     r_state  <= ST_MUL;
                  end else if (w_div_start) begin
                     r_cnt   <= '0;
                     r_state <= ST_DIV;
                  end else begin
                     r_result <= w_res;
                     r_z      <= (w_res == '0);
                     r_n      <= w_res[WIDTH-1];
                     r_c      <= w_c;
                     r_v      <= w_v;
                     r_dbz    <= w_dbz;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_result <= w_acc_next;
                  r_z      <= (w_acc_next == '0);
                  r_n      <= w_acc_next[WIDTH-1];
                  r_c      <= 1'b0;
                  r_v      <= 1'b0;
                  r_dbz    <= 1'b0;
                  r_state  <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DIV: begin
               // Counter tracks the divider's iterations; it saturates at WIDTH-1.
               if (r_cnt != CW'(WIDTH-1)) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (w_div_done) begin
                  r_result <= w_div_q;
                  r_z      <= (w_div_q == '0);
                  r_n      <= w_div_q[WIDTH-1];
                  r_c      <= 1'b0;
                  r_v      <= 1'b0;
                  r_dbz    <= 1'b0;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_DONE);
   assign busy        = (r_state != ST_IDLE);
   assign result      = r_result;
   assign flag_z      = r_z;
   assign flag_n      = r_n;
   assign flag_c      = r_c;
   assign flag_v      = r_v;
   assign div_by_zero = r_dbz;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed bench for seq_alu: inputs driven and outputs sampled on the
// falling edge; latency counted in rising edges from the accepting edge.
// -----------------------------------------------------------------------------
import alu_pkg::*;

module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  alu_sel = 3'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        flag_z, flag_n, flag_c, flag_v;
   logic        div_by_zero;
   logic        busy;
   state_t      dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_sel     (alu_sel),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .flag_z      (flag_z),
      .flag_n      (flag_n),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .div_by_zero (div_by_zero),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // Present one request, then scramble the inputs while busy; returns the
   // number of rising edges until out_valid and whether in_ready was seen high.
   task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit rdy_seen);
      @(negedge clk);
      in_valid = 1'b1; alu_sel = sel; op_a = a; op_b = b;
      @(posedge clk);
      lat = 1; rdy_seen = 1'b0;
      @(negedge clk);
      in_valid = 1'b0; alu_sel = ~sel; op_a = ~a; op_b = ~b;
      while (out_valid !== 1'b1 && lat < 100) begin
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if ({out_valid, busy, result, flag_z, flag_n, flag_c, flag_v, div_by_zero} !== '0) begin
         $display("FAIL reset_outputs: got ov=%b busy=%b res=%h flags=%b%b%b%b dbz=%b want all zero",
                  out_valid, busy, result, flag_z, flag_n, flag_c, flag_v, div_by_zero); n_fail++; end
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
         $display("FAIL reset_ready: got in_ready=%b state=%0d want 1/IDLE", in_ready, dbg_state); n_fail++; end
   endtask

   task automatic test_add();
      int lat; bit rdy;
      issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, lat, rdy);
      n_checks++; if (lat !== 1) begin $display("FAIL add_latency: got %0d want 1", lat); n_fail++; end
      n_checks++; if (result !== 32'h8000_0000) begin $display("FAIL add_ovf_result: got %h want 80000000", result); n_fail++; end
      n_checks++; if ({flag_z, flag_n, flag_c, flag_v, div_by_zero} !== 5'b01010) begin
         $display("FAIL add_ovf_flags: got zncv,dbz=%b%b%b%b%b want 01010", flag_z, flag_n, flag_c, flag_v, div_by_zero); n_fail++; end
      consume();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL add_handshake: got ov=%b rdy=%b want 0/1", out_valid, in_ready); n_fail++; end
      issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, lat, rdy);
      n_checks++; if ({result, flag_z, flag_n, flag_c, flag_v} !== {32'h0, 4'b1010}) begin
         $display("FAIL add_carry: got res=%h zncv=%b%b%b%b want 00000000 1010", result, flag_z, flag_n, flag_c, flag_v); n_fail++; end
      consume();
   endtask

   task automatic test_sub();
      int lat; bit rdy;
      issue(3'b001, 32'd5, 32'd5, lat, rdy);
      n_checks++; if ({result, flag_z, flag_n, flag_c, flag_v} !== {32'h0, 4'b1010}) begin
         $display("FAIL sub_equal: got res=%h zncv=%b%b%b%b want 00000000 1010", result, flag_z, flag_n, flag_c, flag_v); n_fail++; end
      consume();
      issue(3'b001, 32'd3, 32'd5, lat, rdy);
      n_checks++; if ({result, flag_z, flag_n, flag_c, flag_v} !== {32'hFFFF_FFFE, 4'b0100}) begin
         $display("FAIL sub_borrow: got res=%h zncv=%b%b%b%b want fffffffe 0100", result, flag_z, flag_n, flag_c, flag_v); n_fail++; end
      consume();
      issue(3'b001, 32'h8000_0000, 32'd1, lat, rdy);
      n_checks++; if ({result, flag_z, flag_n, flag_c, flag_v} !== {32'h7FFF_FFFF, 4'b0011}) begin
         $display("FAIL sub_ovf: got res=%h zncv=%b%b%b%b want 7fffffff 0011", result, flag_z, flag_n, flag_c, flag_v); n_fail++; end
      consume();
   endtask

   task automatic test_logic_shift();
      int lat; bit rdy;
      issue(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, rdy);
      n_checks++; if ({result, flag_n, flag_c, flag_v} !== {32'h00F0_00F0, 3'b000}) begin
         $display("FAIL and_op: got res=%h ncv=%b%b%b want 00f000f0 000", result, flag_n, flag_c, flag_v); n_fail++; end
      consume();
      issue(3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, rdy);
      n_checks++; if ({result, flag_n} !== {32'hFFF0_FFF0, 1'b1}) begin
         $display("FAIL or_op: got res=%h n=%b want fff0fff0 1", result, flag_n); n_fail++; end
      consume();
      issue(3'b110, 32'h0000_0001, 32'd31, lat, rdy);
      n_checks++; if (result !== 32'h8000_0000) begin $display("FAIL sll_31: got %h want 80000000", result); n_fail++; end
      consume();
      issue(3'b111, 32'h8000_0000, 32'd31, lat, rdy);
      n_checks++; if (result !== 32'h0000_0001) begin $display("FAIL srl_31: got %h want 00000001", result); n_fail++; end
      consume();
      issue(3'b110, 32'h1234_5678, 32'h0000_0020, lat, rdy);
      n_checks++; if (result !== 32'h1234_5678) begin $display("FAIL sll_amt0: got %h want 12345678", result); n_fail++; end
      consume();
      issue(3'b111, 32'h0000_0001, 32'd1, lat, rdy);
      n_checks++; if ({result, flag_z} !== {32'h0, 1'b1}) begin
         $display("FAIL srl_zero: got res=%h z=%b want 00000000 1", result, flag_z); n_fail++; end
      consume();
   endtask

   task automatic test_mul();
      int lat; bit rdy;
      issue(3'b010, 32'h0001_0000, 32'h0001_0003, lat, rdy);
      n_checks++; if (lat !== 33) begin $display("FAIL mul_latency: got %0d want 33", lat); n_fail++; end
      n_checks++; if (rdy !== 1'b0) begin $display("FAIL mul_ready_low: got in_ready seen=%b want 0", rdy); n_fail++; end
      n_checks++; if ({result, flag_z, flag_n, flag_c, flag_v} !== {32'h0003_0000, 4'b0000}) begin
         $display("FAIL mul_result: got res=%h zncv=%b%b%b%b want 00030000 0000", result, flag_z, flag_n, flag_c, flag_v); n_fail++; end
      consume();
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rdy);
      n_checks++; if (result !== 32'h0000_0001) begin $display("FAIL mul_wrap: got %h want 00000001", result); n_fail++; end
      consume();
   endtask

   task automatic test_div();
      int lat; bit rdy;
      issue(3'b011, 32'd100, 32'd7, lat, rdy);
      n_checks++; if (lat !== 33) begin $display("FAIL div_latency: got %0d want 33", lat); n_fail++; end
      n_checks++; if ({result, div_by_zero, rdy} !== {32'd14, 1'b0, 1'b0}) begin
         $display("FAIL div_result: got res=%0d dbz=%b rdy_seen=%b want 14 0 0", result, div_by_zero, rdy); n_fail++; end
      consume();
      issue(3'b011, 32'hFFFF_FFFF, 32'h0001_0000, lat, rdy);
      n_checks++; if (result !== 32'h0000_FFFF) begin $display("FAIL div_large: got %h want 0000ffff", result); n_fail++; end
      consume();
      issue(3'b011, 32'd9, 32'd0, lat, rdy);
      n_checks++; if (lat !== 1) begin $display("FAIL div0_latency: got %0d want 1", lat); n_fail++; end
      n_checks++; if ({result, div_by_zero, flag_n, flag_z} !== {32'hFFFF_FFFF, 3'b110}) begin
         $display("FAIL div0_result: got res=%h dbz=%b n=%b z=%b want ffffffff 1 1 0", result, div_by_zero, flag_n, flag_z); n_fail++; end
      consume();
      issue(3'b000, 32'd1, 32'd1, lat, rdy);
      n_checks++; if ({result, div_by_zero} !== {32'd2, 1'b0}) begin
         $display("FAIL dbz_clear: got res=%h dbz=%b want 00000002 0", result, div_by_zero); n_fail++; end
      consume();
   endtask

   task automatic test_hold();
      int lat; bit rdy; int bad;
      issue(3'b000, 32'd2, 32'd3, lat, rdy);
      bad = 0;
      // New requests offered while in DONE must be ignored.
      in_valid = 1'b1; alu_sel = 3'b100; op_a = 32'hFFFF; op_b = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || result !== 32'd5 || flag_z !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      n_checks++; if (bad !== 0) begin $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); n_fail++; end
      consume();
      n_checks++; if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
         $display("FAIL hold_release: got ov=%b state=%0d want 0/IDLE", out_valid, dbg_state); n_fail++; end
   endtask

   task automatic test_reset_mid_op();
      int lat; bit rdy; int spurious;
      @(negedge clk);
      in_valid = 1'b1; alu_sel = 3'b011; op_a = 32'd1000; op_b = 32'd3;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++; if (busy !== 1'b1 || dbg_state !== ST_DIV) begin
         $display("FAIL mid_div_busy: got busy=%b state=%0d want 1/DIV", busy, dbg_state); n_fail++; end
      rst = 1'b1;
      #1;
      n_checks++; if ({out_valid, busy, result, flag_z, flag_n, flag_c, flag_v, div_by_zero} !== '0 || dbg_state !== ST_IDLE) begin
         $display("FAIL rst_mid_div: got ov=%b busy=%b res=%h state=%0d want 0 0 0 IDLE", out_valid, busy, result, dbg_state); n_fail++; end
      @(negedge clk);
      rst = 1'b0;
      spurious = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
      end
      n_checks++; if (spurious !== 0) begin $display("FAIL rst_no_result: got %0d bad cycles want 0", spurious); n_fail++; end
      issue(3'b000, 32'd1, 32'd2, lat, rdy);
      n_checks++; if (lat !== 1 || result !== 32'd3) begin
         $display("FAIL add_after_rst: got lat=%0d res=%h want 1 00000003", lat, result); n_fail++; end
      // Reset while a result is waiting in DONE.
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
         $display("FAIL rst_in_done: got ov=%b res=%h busy=%b want 0 0 0", out_valid, result, busy); n_fail++; end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic_shift();
      test_mul();
      test_div();
      test_hold();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
